bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 89 ++++++++
 tb/tb_bin2bcd_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter, one bit per cycle,
// with a leading-zero blanking mask for downstream 7-segment decoders.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     nz_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              r_state;
  logic [WIDTH-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_scr;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_nz;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_scr;
  logic [DIGITS-1:0]   w_nz;
  logic                w_seen;
  always_comb begin
    w_adj = '0;
    for (int d = 0; d < DIGITS; d++)
      w_adj[4*d+:4] = (r_scr[4*d+:4] >= 4'd5) ? r_scr[4*d+:4] + 4'd3 : r_scr[4*d+:4];
    w_scr = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
  end
  // A digit is significant if it or any more-significant digit is non-zero.
  always_comb begin
    w_nz = '0;
    w_seen = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_seen = w_seen | (|w_scr[4*d+:4]);
      w_nz[d] = w_seen;
    end
    w_nz[0] = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_nz    <= DIGITS'(1);
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (start_i) begin
          r_bin   <= bin_i;
          r_scr   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_scr <= w_scr;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_bcd   <= w_scr;
            r_nz    <= w_nz;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bcd_o  = r_bcd;
  assign nz_o   = r_nz;
  assign busy_o = r_busy;
  assign done_o = r_done;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and strided-sweep checks of bin2bcd_seq (WIDTH=16, DIGITS=5).
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [4:0]  nz;
  logic        busy, done;
  int          n_checks = 0;
  int          n_fail = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin),
    .bcd_o(bcd), .nz_o(nz), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_nz(input int v);
    logic [4:0] m = 5'b00001;
    int p = 1;
    for (int d = 0; d < 5; d++) begin
      if (v >= p) m[d] = 1'b1;
      p = p * 10;
    end
    return m;
  endfunction

  // Issues start, tracks latency/busy/stability, optionally injects a stray start mid-shift.
  task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd, input logic [4:0] exp_nz,
                         input bit full, input bit inject);
    logic [19:0] prev_bcd = bcd;
    logic [4:0]  prev_nz = nz;
    int n = 0, busy_n = 0;
    bit stable = 1'b1;
    start = 1'b1;
    bin = v;
    @(posedge clk); #1;
    start = 1'b0;
    bin = 16'hA5A5;
    if (busy) busy_n++;
    while (!done && n < 40) begin
      if (inject && n == 5) begin start = 1'b1; bin = 16'd500; end
      if (inject && n == 6) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
      if (!done && (bcd !== prev_bcd || nz !== prev_nz)) stable = 1'b0;
    end
    if (full) begin
      check($sformatf("latency %0d", v), n, 16);
      check($sformatf("busy cycles %0d", v), busy_n, 16);
      check($sformatf("hold prev %0d", v), stable, 1);
    end
    check($sformatf("bcd %0d", v), bcd, exp_bcd);
    check($sformatf("nz %0d", v), nz, exp_nz);
    @(posedge clk); #1;
    if (full) check($sformatf("done one cycle %0d", v), {busy, done}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; bin = 16'd77;
    repeat (2) @(posedge clk);
    #1;
    check("reset bcd", bcd, 0);
    check("reset nz", nz, 5'b00001);
    check("reset busy/done", {busy, done}, 2'b00);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    convert(16'd0,     20'h00000, 5'b00001, 1, 0);
    convert(16'd65535, 20'h65535, 5'b11111, 1, 0);
    convert(16'd1234,  20'h01234, 5'b01111, 1, 0);
    convert(16'd9,     20'h00009, 5'b00001, 1, 0);
    convert(16'd42,    20'h00042, 5'b00011, 1, 1);
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || done) break;
    end
    check("stray start dropped", {busy, done, bcd}, {2'b00, 20'h00042});

    start = 1'b1; bin = 16'd9999;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort bcd", bcd, 0);
    check("abort nz", nz, 5'b00001);
    check("abort busy/done", {busy, done}, 2'b00);
    begin
      bit seen = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        if (done || busy) seen = 1'b1;
      end
      check("abort no done", seen, 0);
    end
    convert(16'd100, 20'h00100, 5'b00111, 1, 0);
    convert(16'd10000, 20'h10000, 5'b11111, 0, 0);
    convert(16'd9999, 20'h09999, 5'b01111, 0, 0);

    for (int i = 0; i < 256; i++) begin
      int v = i * 257 + (i % 7);
      if (v > 65535) v = 65535;
      convert(16'(v), ref_bcd(v), ref_nz(v), 0, 0);
      begin
        bit ok = 1'b1;
        for (int d = 0; d < 5; d++) if (bcd[4*d+:4] > 4'd9) ok = 1'b0;
        check($sformatf("nibbles<=9 %0d", v), ok, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
